npu_data_loader: RTL and testbench



---
 rtl/npu_data_loader.sv | 119 +++++++++++
 tb/tb_npu_data_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/npu_data_loader.sv
// npu_data_loader: streams a length header plus (feature, weight) byte pairs into the NPU RAMs, then launches the core.
// Define NPU_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte and expose err_csum.
module npu_data_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              feat_we,
   output logic [ADDR_W-1:0] feat_addr,
   output logic [DATA_W-1:0] feat_wdata,
   output logic              weight_we,
   output logic [ADDR_W-1:0] weight_addr,
   output logic [DATA_W-1:0] weight_wdata,
   output logic [ADDR_W:0]   vec_len,
   output logic              core_start,
   input  logic              core_done,
   output logic              busy,
   output logic              err_len,
`ifdef NPU_LOADER_CHECKSUM_EN
   output logic              err_csum,
`endif
   output logic [15:0]       vec_count
);
   typedef enum logic [2:0] {
      IDLE,
      LOAD_F,
      LOAD_W,
`ifdef NPU_LOADER_CHECKSUM_EN
      CSUM,
`endif
      START,
      WAIT_DONE
   } state_t;

`ifdef NPU_LOADER_CHECKSUM_EN
   localparam state_t LAST_NXT = CSUM;
   logic [DATA_W-1:0] csum;
`else
   localparam state_t LAST_NXT = START;
`endif
   localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_W;

   state_t state, nxt;
   logic [ADDR_W-1:0] idx;
   logic hs, hdr_ok, last;

   assign hs      = s_valid && s_ready;
   assign hdr_ok  = (s_data != '0) && (32'(s_data) <= MAX_LEN);
   assign last    = ({1'b0, idx} + (ADDR_W+1)'(1)) == vec_len;
   assign s_ready = (state != START) && (state != WAIT_DONE);
   assign busy    = state != IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = (hs && hdr_ok) ? LOAD_F : IDLE;
         LOAD_F:    nxt = hs ? LOAD_W : LOAD_F;
         LOAD_W:    nxt = hs ? (last ? LAST_NXT : LOAD_F) : LOAD_W;
`ifdef NPU_LOADER_CHECKSUM_EN
         CSUM:      nxt = hs ? ((s_data == csum) ? START : IDLE) : CSUM;
`endif
         START:     nxt = WAIT_DONE;
         WAIT_DONE: nxt = core_done ? IDLE : WAIT_DONE;
         default:   nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         feat_we      <= 1'b0;
         feat_addr    <= '0;
         feat_wdata   <= '0;
         weight_we    <= 1'b0;
         weight_addr  <= '0;
         weight_wdata <= '0;
         vec_len      <= '0;
         core_start   <= 1'b0;
         err_len      <= 1'b0;
         vec_count    <= '0;
         idx          <= '0;
`ifdef NPU_LOADER_CHECKSUM_EN
         csum         <= '0;
         err_csum     <= 1'b0;
`endif
      end else begin
         feat_we    <= hs && (state == LOAD_F);
         weight_we  <= hs && (state == LOAD_W);
         err_len    <= hs && (state == IDLE) && !hdr_ok;
         core_start <= state == START;
         if (hs && state == IDLE && hdr_ok) begin
            vec_len <= s_data[ADDR_W:0];
            idx     <= '0;
         end
         if (hs && state == LOAD_F) begin
            feat_addr  <= idx;
            feat_wdata <= s_data;
         end
         if (hs && state == LOAD_W) begin
            weight_addr  <= idx;
            weight_wdata <= s_data;
            idx          <= idx + ADDR_W'(1);
         end
         if (state == WAIT_DONE && core_done) vec_count <= vec_count + 16'd1;
`ifdef NPU_LOADER_CHECKSUM_EN
         // Running XOR seeded by the header, folded over every payload byte.
         if (hs && state == IDLE) csum <= s_data;
         if (hs && (state == LOAD_F || state == LOAD_W)) csum <= csum ^ s_data;
         err_csum <= hs && (state == CSUM) && (s_data != csum);
`endif
      end
endmodule

// File: tb/tb_npu_data_loader.sv
// tb_npu_data_loader: randomized scoreboard bench for npu_data_loader (default build, checksum disabled).
module tb_npu_data_loader;
   localparam int AW = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic s_valid = 1'b0;
   logic core_done = 1'b0;
   logic s_ready, feat_we, weight_we, core_start, busy, err_len;
   logic [AW-1:0] feat_addr, weight_addr;
   logic [DW-1:0] feat_wdata, weight_wdata;
   logic [AW:0] vec_len;
   logic [15:0] vec_count;

   int n_vec = 0, n_bad = 0;
   int exp_count = 0, err_exp = 0, spur_cnt = 0, spur_seen = 0;
   int cyc = 0, last_w = 0, dly = 0;
   logic [AW+DW-1:0] fq[$], wq[$];
   logic [AW:0] sq[$];
   logic [DW-1:0] vf[16], vw[16];

   always #5 clk = ~clk;

   npu_data_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .feat_we(feat_we), .feat_addr(feat_addr), .feat_wdata(feat_wdata),
      .weight_we(weight_we), .weight_addr(weight_addr), .weight_wdata(weight_wdata),
      .vec_len(vec_len), .core_start(core_start), .core_done(core_done),
      .busy(busy), .err_len(err_len), .vec_count(vec_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      logic [AW:0] l;
      if (rst_n) begin
         cyc++;
         if (feat_we) begin
            chk("feat_write_expected", 32'(fq.size() > 0), 1);
            if (fq.size() > 0) begin
               e = fq.pop_front();
               chk("feat_write", 32'({feat_addr, feat_wdata}), 32'(e));
            end
         end
         if (weight_we) begin
            last_w = cyc;
            chk("weight_write_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
               e = wq.pop_front();
               chk("weight_write", 32'({weight_addr, weight_wdata}), 32'(e));
            end
         end
         if (core_start) begin
            chk("core_start_expected", 32'(sq.size() > 0), 1);
            if (sq.size() > 0) begin
               l = sq.pop_front();
               chk("start_vec_len", 32'(vec_len), 32'(l));
               chk("start_latency", cyc - last_w, 1);
            end
         end
         if (err_len) begin
            chk("err_len_expected", 32'(err_exp > 0), 1);
            if (err_exp > 0) err_exp--;
         end
      end
   end

   // Core model: answers each launch after a random delay; can also inject a stray done.
   initial begin
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         if (spur_cnt != spur_seen) begin
            core_done = 1'b1;
            spur_seen++;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) core_done = 1'b1;
         end else if (core_start) dly = int'($urandom_range(4, 1));
      end
   end

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
   endtask

   task automatic send(input logic [DW-1:0] b, input int gm);
      int t = 0;
      int g = (gm == 0) ? 0 : (gm == 1) ? 1 : int'($urandom_range(2, 0));
      if (g > 0) begin
         s_valid = 1'b0;
         repeat (g) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data = b;
      while (!s_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         n_bad++;
         $display("FAIL send_timeout: s_ready got 0 expected 1");
         summary();
         $fatal(1, "stream stalled");
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 200) begin
         chk("s_ready_while_busy", 32'(s_ready), 0);
         @(negedge clk);
         t++;
      end
      s_valid = 1'b0;
      chk("busy_timeout", 32'(busy), 0);
      chk("vec_count", 32'(vec_count), 32'(exp_count & 16'hFFFF));
      chk("s_ready_idle", 32'(s_ready), 1);
   endtask

   task automatic send_vec(input int n, input int gm, input bit spur);
      send(DW'(n), gm);
      if (spur) begin
         spur_cnt++;
         repeat (3) @(negedge clk);
      end
      for (int i = 0; i < n; i++) begin
         fq.push_back({AW'(i), vf[i]});
         wq.push_back({AW'(i), vw[i]});
         send(vf[i], gm);
         send(vw[i], gm);
      end
      sq.push_back((AW+1)'(n));
      exp_count++;
      s_valid = 1'b1;
      s_data = 8'hA5;
      wait_idle();
   endtask

   task automatic send_bad(input logic [DW-1:0] b);
      err_exp++;
      send(b, 0);
   endtask

   task automatic chk_reset();
      chk("rst_feat_we", 32'(feat_we), 0);
      chk("rst_weight_we", 32'(weight_we), 0);
      chk("rst_addrs", 32'({feat_addr, weight_addr}), 0);
      chk("rst_wdata", 32'({feat_wdata, weight_wdata}), 0);
      chk("rst_vec_len", 32'(vec_len), 0);
      chk("rst_vec_count", 32'(vec_count), 0);
      chk("rst_pulses", 32'({core_start, err_len, busy}), 0);
      chk("rst_s_ready", 32'(s_ready), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      @(negedge clk);
      vf[0] = 8'd10; vw[0] = 8'd2;
      vf[1] = 8'd5;  vw[1] = 8'hFD;
      vf[2] = 8'd2;  vw[2] = 8'd4;
      send_vec(3, 0, 1'b0);
      send_vec(3, 1, 1'b0);
      send_bad(8'd0);
      send_bad(8'd17);
      for (int i = 0; i < 16; i++) begin
         vf[i] = DW'($urandom);
         vw[i] = DW'($urandom);
      end
      send_vec(16, 0, 1'b0);
      send_vec(3, 2, 1'b1);
      // Abandon an N=3 load after two pairs.
      send(8'd3, 0);
      for (int i = 0; i < 2; i++) begin
         fq.push_back({AW'(i), vf[i]});
         wq.push_back({AW'(i), vw[i]});
         send(vf[i], 0);
         send(vw[i], 0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
      exp_count = 0;
      @(negedge clk);
      vf[0] = 8'd7; vw[0] = 8'd9;
      send_vec(1, 0, 1'b0);
      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(5, 0) == 0)
            send_bad($urandom_range(1, 0) != 0 ? 8'd0 : DW'($urandom_range(255, 17)));
         else begin
            int n = int'($urandom_range(16, 1));
            for (int i = 0; i < n; i++) begin
               vf[i] = DW'($urandom);
               vw[i] = DW'($urandom);
            end
            send_vec(n, 2, $urandom_range(3, 0) == 0);
         end
      end
      repeat (4) @(negedge clk);
      chk("feat_writes_drained", 32'(fq.size()), 0);
      chk("weight_writes_drained", 32'(wq.size()), 0);
      chk("starts_drained", 32'(sq.size()), 0);
      chk("err_len_drained", 32'(err_exp), 0);
      summary();
      $finish;
   end
endmodule
